// File: rtl/result_serializer_if.sv
// Bus between the result serializer and its environment (controller + UART).
interface result_serializer_if #(
    parameter int unsigned ELEM_W    = 16,
    parameter int unsigned NUM_ELEMS = 9
) ();
    logic                          start;
    logic [3:0]                    matrix_size;
    logic [ELEM_W*NUM_ELEMS-1:0]   result;
    logic                          tx_busy;
    logic [7:0]                    tx_data;
    logic                          tx_start;
    logic                          busy;
    logic                          done;

    // Environment side: issues requests and reports UART state.
    modport master (
        output start, matrix_size, result, tx_busy,
        input  tx_data, tx_start, busy, done
    );

    // Serializer side.
    modport slave (
        input  start, matrix_size, result, tx_busy,
        output tx_data, tx_start, busy, done
    );
endinterface

// File: rtl/result_serializer.sv
// Streams the active N x N part of a packed 3x3 result to a byte UART,
// high byte first per element, row-major order.
module result_serializer #(
    parameter int unsigned ELEM_W    = 16,
    parameter int unsigned NUM_ELEMS = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    result_serializer_if.slave   bus
);

    localparam int unsigned RES_W   = ELEM_W * NUM_ELEMS;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DIM_W   = 2;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned WCNT_W  = 3;
    localparam int unsigned TIMEOUT = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [DIM_W-1:0]    row, row_nxt;
    logic [DIM_W-1:0]    col, col_nxt;
    logic                byte_sel, byte_sel_nxt;
    logic [DIM_W-1:0]    n_snap, n_snap_nxt;
    logic [RES_W-1:0]    res_snap, res_snap_nxt;
    logic [WCNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_nxt;
    logic                tx_start_q, tx_start_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;

    logic [DIM_W-1:0]    n_clamp_c;
    logic [IDX_W-1:0]    elem_idx_c;
    logic [ELEM_W-1:0]   elems [NUM_ELEMS];
    logic [ELEM_W-1:0]   elem_c;
    logic [BYTE_W-1:0]   byte_c;
    logic                last_col_c;
    logic                last_row_c;
    logic                advance_c;

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // Clamp requested dimension: 1..3 as-is, anything else means full 3x3.
    always_comb begin
        if (bus.matrix_size == 4'd0 || bus.matrix_size > 4'd3)
            n_clamp_c = DIM_W'(3);
        else
            n_clamp_c = bus.matrix_size[DIM_W-1:0];
    end

    // Select the current byte out of the snapshot.
    always_comb begin
        for (int unsigned k = 0; k < NUM_ELEMS; k++)
            elems[k] = res_snap[k*ELEM_W +: ELEM_W];
        elem_idx_c = IDX_W'(row) * IDX_W'(3) + IDX_W'(col);
        elem_c     = elems[elem_idx_c];
        byte_c     = byte_sel ? elem_c[BYTE_W-1:0] : elem_c[ELEM_W-1 -: BYTE_W];
        last_col_c = (col == DIM_W'(n_snap - DIM_W'(1)));
        last_row_c = (row == DIM_W'(n_snap - DIM_W'(1)));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt    = state;
        row_nxt      = row;
        col_nxt      = col;
        byte_sel_nxt = byte_sel;
        n_snap_nxt   = n_snap;
        res_snap_nxt = res_snap;
        wait_cnt_nxt = wait_cnt;
        tx_data_nxt  = tx_data_q;
        tx_start_nxt = 1'b0;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        advance_c    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    res_snap_nxt = bus.result;
                    n_snap_nxt   = n_clamp_c;
                    row_nxt      = '0;
                    col_nxt      = '0;
                    byte_sel_nxt = 1'b0;
                    busy_nxt     = 1'b1;
                    state_nxt    = LOAD;
                end
            end
            LOAD: begin
                tx_data_nxt = byte_c;
                state_nxt   = SEND;
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    tx_start_nxt = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A UART that never reports busy is assumed done after the timeout.
                if (bus.tx_busy)
                    state_nxt = WAIT_IDLE;
                else if (wait_cnt == WCNT_W'(TIMEOUT - 1))
                    advance_c = 1'b1;
                else
                    wait_cnt_nxt = wait_cnt + WCNT_W'(1);
            end
            WAIT_IDLE: begin
                if (!bus.tx_busy)
                    advance_c = 1'b1;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (advance_c) begin
            state_nxt = LOAD;
            if (!byte_sel) begin
                byte_sel_nxt = 1'b1;
            end else begin
                byte_sel_nxt = 1'b0;
                if (!last_col_c) begin
                    col_nxt = col + DIM_W'(1);
                end else begin
                    col_nxt = '0;
                    if (last_row_c) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        row_nxt = row + DIM_W'(1);
                    end
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            byte_sel   <= 1'b0;
            n_snap     <= '0;
            res_snap   <= '0;
            wait_cnt   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            byte_sel   <= byte_sel_nxt;
            n_snap     <= n_snap_nxt;
            res_snap   <= res_snap_nxt;
            wait_cnt   <= wait_cnt_nxt;
            tx_data_q  <= tx_data_nxt;
            tx_start_q <= tx_start_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer with a simple UART busy model.
module tb_result_serializer;

    localparam int unsigned ELEM_W    = 16;
    localparam int unsigned NUM_ELEMS = 9;
    localparam int unsigned RES_W     = ELEM_W * NUM_ELEMS;

    logic clk;
    logic rst;

    result_serializer_if #(.ELEM_W(ELEM_W), .NUM_ELEMS(NUM_ELEMS)) bus ();

    result_serializer #(.ELEM_W(ELEM_W), .NUM_ELEMS(NUM_ELEMS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int         exp_done   = 0;
    int         done_seen  = 0;
    int         bytes_seen = 0;
    int         cyc        = 0;
    int         stamps[$];
    logic [7:0] last_exp   = 8'h00;
    logic       prev_start = 1'b0;

    // UART model: busy for uart_len cycles after each load strobe (0 = never busy).
    int uart_len = 10;
    int ucnt;
    always @(posedge clk or negedge rst) begin
        if (!rst)
            ucnt <= 0;
        else if (bus.tx_start && uart_len != 0)
            ucnt <= uart_len;
        else if (ucnt != 0)
            ucnt <= ucnt - 1;
    end
    assign bus.tx_busy = (ucnt != 0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compares every strobed byte and done pulse against the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.tx_start) begin
                    checks++; errors++;
                    $display("FAIL reset_strobe: tx_start=1 while reset asserted");
                end
            end else begin
                if (bus.tx_start) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_strobe: got byte %02h, none expected", bus.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.tx_data !== e) begin
                            errors++;
                            $display("FAIL byte[%0d]: got %02h expected %02h", bytes_seen, bus.tx_data, e);
                        end
                    end
                    checks++;
                    if (bus.tx_busy || prev_start) begin
                        errors++;
                        $display("FAIL strobe_overlap: tx_busy=%0b prev_start=%0b expected 0,0", bus.tx_busy, prev_start);
                    end
                    stamps.push_back(cyc);
                    bytes_seen++;
                end
                if (bus.done) begin
                    checks++;
                    if (exp_done == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: done=1 with no transaction pending");
                    end else if (exp_q.size() != 0 || bus.busy) begin
                        errors++;
                        $display("FAIL done_early: pending=%0d busy=%0b expected 0,0", exp_q.size(), bus.busy);
                    end else begin
                        exp_done--;
                    end
                    done_seen++;
                end
            end
            prev_start = bus.tx_start;
        end
    end

    // Reference model: bytes a transaction must produce.
    task automatic push_expected(input logic [RES_W-1:0] res, input logic [3:0] ms);
        int n;
        logic [15:0] e;
        n = (ms >= 4'd1 && ms <= 4'd3) ? int'(ms) : 3;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                e = res[(r*3 + c)*16 +: 16];
                exp_q.push_back(e[15:8]);
                exp_q.push_back(e[7:0]);
                last_exp = e[7:0];
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic launch_txn(input logic [RES_W-1:0] res, input logic [3:0] ms, input int len);
        uart_len         = len;
        bus.result      = res;
        bus.matrix_size = ms;
        push_expected(res, ms);
        exp_done++;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("busy_rise", 32'(bus.busy), 32'd1);
    endtask

    task automatic finish_txn(input int target);
        for (int i = 0; i < 6000 && done_seen < target; i++)
            @(negedge clk);
        if (done_seen < target) begin
            checks++; errors++;
            $display("FAIL done_timeout: done_seen=%0d expected %0d", done_seen, target);
        end
        @(negedge clk);
        check_val("done_width", 32'(bus.done), 32'd0);
        check_val("busy_after_done", 32'(bus.busy), 32'd0);
        check_val("tx_data_hold", 32'(bus.tx_data), 32'(last_exp));
    endtask

    task automatic run_txn(input logic [RES_W-1:0] res, input logic [3:0] ms, input int len);
        int target;
        target = done_seen + 1;
        launch_txn(res, ms, len);
        finish_txn(target);
    endtask

    logic [RES_W-1:0] base_res;
    logic [RES_W-1:0] rnd_res;
    int               target;
    int               first_stamp;

    initial begin
        rst             = 1'b0;
        bus.start       = 1'b0;
        bus.matrix_size = 4'd3;
        bus.result      = '0;
        for (int k = 0; k < 9; k++)
            base_res[k*16 +: 16] = 16'h0100 + 16'(k);

        // Reset values
        repeat (2) @(negedge clk);
        check_val("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_tx_data", 32'(bus.tx_data), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: N=3, N=2, clamped sizes, N=1
        run_txn(base_res, 4'd3, 10);
        check_val("bytes_n3", 32'(bytes_seen), 32'd18);
        run_txn(base_res, 4'd2, 10);
        check_val("bytes_n2", 32'(bytes_seen), 32'd26);
        run_txn(base_res, 4'd0, 10);
        run_txn(base_res, 4'd7, 10);
        check_val("bytes_clamp", 32'(bytes_seen), 32'd62);
        run_txn(base_res, 4'd1, 3);

        // Restart and result change during transmission are ignored
        target = done_seen + 1;
        launch_txn(base_res, 4'd3, 10);
        repeat (30) @(negedge clk);
        bus.result      = {RES_W{1'b1}};
        bus.matrix_size = 4'd1;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
        repeat (40) @(negedge clk);
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
        finish_txn(target);
        repeat (60) @(negedge clk);
        check_val("no_second_txn_busy", 32'(bus.busy), 32'd0);
        check_val("no_second_txn_bytes", 32'(bytes_seen), 32'd82);

        // Reset after the 5th byte aborts; next start begins at element 0 high byte
        target = bytes_seen + 5;
        launch_txn(base_res, 4'd3, 10);
        for (int i = 0; i < 2000 && bytes_seen < target; i++)
            @(negedge clk);
        check_val("mid_bytes", 32'(bytes_seen), 32'(target));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_done = 0;
        #1;
        check_val("abort_tx_start", 32'(bus.tx_start), 32'd0);
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        check_val("abort_tx_data", 32'(bus.tx_data), 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 9; k++)
            rnd_res[k*16 +: 16] = 16'hA050 + 16'(k * 16'h0111);
        run_txn(rnd_res, 4'd3, 10);

        // UART never busy: each byte advances via the 4-cycle timeout
        first_stamp = stamps.size();
        run_txn(base_res, 4'd2, 0);
        check_val("timeout_bytes", 32'(stamps.size() - first_stamp), 32'd8);
        for (int i = first_stamp + 1; i < stamps.size(); i++)
            check_val("timeout_interval", 32'(stamps[i] - stamps[i-1]), 32'd6);

        // Randomized transactions
        for (int t = 0; t < 12; t++) begin
            for (int w = 0; w < 9; w++)
                rnd_res[w*16 +: 16] = 16'($urandom);
            run_txn(rnd_res, 4'($urandom_range(0, 15)), int'($urandom_range(0, 12)));
        end

        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter ELEM_W, default 16, result element width in bits (two bytes per element).
REQ-002 Parameter NUM_ELEMS, default 9, elements in the packed 3x3 result, row-major.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to transmit the current result.
REQ-006 matrix_size  input  4  active dimension N of the square result.
REQ-007 result  input  144  packed result; element k = row*3+col occupies bits [16k+15:16k].
REQ-008 tx_busy  input  1  busy flag from the UART transmitter.
REQ-009 tx_data  output  8  byte presented to the UART transmitter.
REQ-010 tx_start  output  1  one-cycle load strobe to the UART transmitter.
REQ-011 busy  output  1  high from accepted start until done.
REQ-012 done  output  1  one-cycle pulse after the final byte completes.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, SEND, WAIT_BUSY, WAIT_IDLE, DONE.
REQ-014 IDLE: start=1 -> snapshot result and N into internal registers, clear row/col/byte counters, go to LOAD; busy rises the next cycle.
REQ-015 start SHALL be ignored in every state except IDLE; snapshot is immune to later result/matrix_size changes.
REQ-016 N clamp: matrix_size 1..3 used as-is; 0 or >3 treated as 3.
REQ-017 LOAD: tx_data <= selected byte; go to SEND.
REQ-018 SEND: when tx_busy=0, assert tx_start for exactly one cycle with tx_data stable, go to WAIT_BUSY; else hold.
REQ-019 WAIT_BUSY: on tx_busy=1 go to WAIT_IDLE; after 4 cycles without tx_busy=1, treat byte as sent and advance as in REQ-020.
REQ-020 WAIT_IDLE: on tx_busy=0 advance: byte 0->1 stays same element; byte 1 -> next element; go to LOAD, or DONE after last byte.
REQ-021 Byte order: per element high byte [15:8] first, then low byte [7:0].
REQ-022 Element order: row 0..N-1, col 0..N-1 within each row; elements with row>=N or col>=N SHALL NOT be sent.
REQ-023 Total bytes per transaction SHALL equal 2*N*N (2, 8, or 18).
REQ-024 DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
REQ-025 tx_data SHALL hold its last value between bytes and after DONE.
REQ-026 tx_start SHALL never assert while tx_busy=1 or outside SEND.
REQ-027 Element index SHALL be row*3+col, computed from the 2-bit row/col counters; no wrap beyond index 8.

Reset
REQ-028 rst=0 SHALL force IDLE immediately: tx_start=0, busy=0, done=0, tx_data=8'h00, counters and snapshot cleared.
REQ-029 Reset mid-transaction SHALL abort without further tx_start; first start after release begins at element 0, high byte.
REQ-030 Outputs SHALL be driven from registers only.

Verification
REQ-031 N=3, result elements k=0..8 = 16'h0100+k, UART model busy 10 cycles per byte -> 18 bytes 01,00,01,01,...,01,08; done one pulse; tx_start never overlaps tx_busy.
REQ-032 N=2, same result -> 8 bytes 01,00,01,01,01,03,01,04 (elements 0,1,3,4); done after 8th byte.
REQ-033 matrix_size=0 and matrix_size=7 -> 18 bytes, identical to N=3.
REQ-034 start re-pulsed and result changed to all 16'hFFFF during transmission -> original bytes unaffected, no second transaction.
REQ-035 rst=0 asserted after 5th byte, then released and start pulsed -> no tx_start during reset; new sequence begins with element 0 high byte.
REQ-036 tx_busy held 0 permanently -> each byte advances after 4-cycle WAIT_BUSY timeout; all 2*N*N strobes emitted, then done.
